// File: rtl/azimuth_frame_loader_pkg.sv
// Shared constants and helpers for the azimuth frame loader: state encoding,
// counter width and frame-geometry functions.
package azimuth_frame_loader_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Ceiling log2, never less than 1 so a single-word frame still gets an index bit.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(value)) r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int words_for(input int size, input int word_w);
    return (size + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/azimuth_frame_loader_if.sv
// Word stream carrying one sweep mask per TLAST-framed packet.
interface azimuth_frame_loader_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/azimuth_frame_buffer.sv
// Back buffer with a word write port and a whole-buffer copy into the front
// buffer on the swap strobe; the front buffer only ever changes as a whole.
module azimuth_frame_buffer #(
  parameter int SIZE   = 3200,
  parameter int WORD_W = 32,
  parameter int WORDS  = 100,
  parameter int IDX_W  = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic              swap_i,
  output logic [SIZE-1:0]   data_o
);

  logic [WORDS*WORD_W-1:0] back_q;
  logic [SIZE-1:0]         front_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      back_q  <= '0;
      front_q <= '0;
    end else begin
      if (wr_en_i) back_q[int'(wr_idx_i)*WORD_W +: WORD_W] <= wr_data_i;
      // Padding bits of the last word beyond SIZE are dropped here.
      if (swap_i) front_q <= back_q[SIZE-1:0];
    end
  end

  assign data_o = front_q;

endmodule

// File: rtl/azimuth_frame_loader.sv
// Assembles stream frames into a back buffer and swaps them onto the sweep
// DATA bus on each trigger rising edge; flags underruns and malformed frames.
module azimuth_frame_loader
  import azimuth_frame_loader_pkg::*;
#(
  parameter int SIZE    = 3200,
  parameter int WORD_W  = 32,
  parameter int CNT_W_P = CNT_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 trig_i,
  azimuth_frame_loader_if.slave s,
  output logic [SIZE-1:0]      data_o,
  output logic                 frame_ok_o,
  output logic                 underrun_o,
  output logic                 frame_err_o,
  output logic [CNT_W_P-1:0]   swap_cnt_o,
  output logic [CNT_W_P-1:0]   underrun_cnt_o
);

  localparam int WORDS = words_for(SIZE, WORD_W);
  localparam int IDX_W = clogb2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               trig_q;
  logic               frame_ok_q;
  logic               underrun_q;
  logic               frame_err_q;
  logic [CNT_W_P-1:0] swap_cnt_q;
  logic [CNT_W_P-1:0] underrun_cnt_q;

  logic tready;
  logic rise;
  logic accept;
  logic swap;

  // Gated by reset so the stream sees no ready while the block is held in reset.
  assign tready = en_i && (state_q == ST_FILL) && !rst_i;
  assign rise   = trig_i && !trig_q;
  assign accept = s.tvalid && tready;
  assign swap   = en_i && (state_q == ST_READY) && rise;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_FILL;
      idx_q          <= '0;
      trig_q         <= 1'b0;
      frame_ok_q     <= 1'b0;
      underrun_q     <= 1'b0;
      frame_err_q    <= 1'b0;
      swap_cnt_q     <= '0;
      underrun_cnt_q <= '0;
    end else begin
      trig_q      <= trig_i;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (!en_i) begin
        state_q    <= ST_FILL;
        idx_q      <= '0;
        frame_ok_q <= 1'b0;
      end else begin
        case (state_q)
          ST_FILL: begin
            if (accept) begin
              if (idx_q == LAST_IDX) begin
                idx_q <= '0;
                if (s.tlast) state_q     <= ST_READY;
                else         frame_err_q <= 1'b1;
              end else if (s.tlast) begin
                idx_q       <= '0;
                frame_err_q <= 1'b1;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end
            // A final word landing on the trigger edge still completes the frame,
            // but this sweep repeats the old mask.
            if (rise) begin
              underrun_q <= 1'b1;
              if (underrun_cnt_q != '1) underrun_cnt_q <= underrun_cnt_q + 1'b1;
            end
          end
          ST_READY: begin
            if (rise) begin
              swap_cnt_q <= swap_cnt_q + 1'b1;
              frame_ok_q <= 1'b1;
              state_q    <= ST_FILL;
            end
          end
          default: state_q <= ST_FILL;
        endcase
      end
    end
  end

  azimuth_frame_buffer #(
    .SIZE   (SIZE),
    .WORD_W (WORD_W),
    .WORDS  (WORDS),
    .IDX_W  (IDX_W)
  ) u_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (accept),
    .wr_idx_i  (idx_q),
    .wr_data_i (s.tdata),
    .swap_i    (swap),
    .data_o    (data_o)
  );

  assign s.tready       = tready;
  assign frame_ok_o     = frame_ok_q;
  assign underrun_o     = underrun_q;
  assign frame_err_o    = frame_err_q;
  assign swap_cnt_o     = swap_cnt_q;
  assign underrun_cnt_o = underrun_cnt_q;

endmodule
